// File: rtl/oscope_pkg.sv
// Shared types for the oscilloscope capture datapath.
package oscope_pkg;

    // Capture engine states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FULL    = 2'd3
    } cap_state_t;

    // Trigger source selection, encoded as driven on the trig_mode port.
    typedef enum logic [1:0] {
        TRIG_FREE = 2'd0,
        TRIG_RISE = 2'd1,
        TRIG_FALL = 2'd2,
        TRIG_EXT  = 2'd3
    } trig_mode_t;

    // Width of the decimation ratio and its counter.
    localparam int DECIM_W = 8;

endpackage

// File: rtl/adc_serial_rx.sv
// Serial ADC frame engine: SCLK divider, conversion strobe timing and
// MSB-first shift-in of the sample field of each conversion frame.
module adc_serial_rx #(
    parameter int FRAME_BITS = 16,
    parameter int LEAD_PAD   = 2,
    parameter int DATA_W     = 8,
    parameter int QUIET_BITS = 2,
    parameter int SCLK_DIV   = 4
) (
    input  logic              osc_clk,
    input  logic              reset,
    input  logic              adc_data,
    output logic              adc_conv,
    output logic              adc_clk,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid
);

    // One frame is QUIET_BITS periods with adc_conv high followed by
    // FRAME_BITS data periods; a period runs from one SCLK fall to the next.
    localparam int PERIODS  = FRAME_BITS + QUIET_BITS;
    localparam int PER_W    = $clog2(PERIODS);
    localparam int DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int FIELD_LO = QUIET_BITS + LEAD_PAD;
    localparam int FIELD_HI = QUIET_BITS + LEAD_PAD + DATA_W - 1;

    logic [DIV_W-1:0]  div_cnt;
    logic [PER_W-1:0]  per_cnt;
    logic [PER_W-1:0]  per_nxt;
    logic              tick;
    logic              rise_evt;
    logic              fall_evt;
    logic              in_field;
    logic [DATA_W-1:0] shift_p0;
    logic              vld_p0;

    assign tick     = (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign rise_evt = tick & ~adc_clk;
    assign fall_evt = tick & adc_clk;
    assign per_nxt  = (per_cnt == PER_W'(PERIODS - 1)) ? '0 : per_cnt + 1'b1;
    // Only the rises that carry sample bits are shifted in; pad bits are dropped.
    assign in_field = (per_cnt >= PER_W'(FIELD_LO)) && (per_cnt <= PER_W'(FIELD_HI));

    // SCLK divider, period counter, conversion strobe and end-of-frame pulse.
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            div_cnt  <= '0;
            adc_clk  <= 1'b0;
            adc_conv <= 1'b1;
            per_cnt  <= '0;
            vld_p0   <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                adc_clk <= ~adc_clk;
            end
            if (fall_evt) begin
                per_cnt  <= per_nxt;
                adc_conv <= (per_nxt < PER_W'(QUIET_BITS));
            end
            vld_p0 <= rise_evt && !adc_conv && (per_cnt == PER_W'(PERIODS - 1));
        end
    end

    // Stage p0: MSB-first shift register sampled on the edge SCLK goes high.
    always_ff @(posedge osc_clk) begin
        if (rise_evt && !adc_conv && in_field) begin
            shift_p0 <= {shift_p0[DATA_W-2:0], adc_data};
        end
    end

    assign sample       = shift_p0;
    assign sample_valid = vld_p0;

endmodule

// File: rtl/adc_capture_buffer.sv
// ADC capture engine: frame engine, trigger, decimator, capture FSM and
// single-clock sample buffer read back by the Pi once full.
module adc_capture_buffer
    import oscope_pkg::*;
#(
    parameter int FRAME_BITS = 16,
    parameter int LEAD_PAD   = 2,
    parameter int DATA_W     = 8,
    parameter int QUIET_BITS = 2,
    parameter int SCLK_DIV   = 4,
    parameter int DEPTH      = 1024,
    localparam int ADR_W     = $clog2(DEPTH)
) (
    input  logic              osc_clk,
    input  logic              reset,
    input  logic              adc_data,
    output logic              adc_conv,
    output logic              adc_clk,
    input  logic              arm,
    input  logic [1:0]        trig_mode,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_ext,
    input  logic [7:0]        decim,
    output logic              pi_signal_flag,
    input  logic              rd_en,
    input  logic [ADR_W-1:0]  rd_adr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(DEPTH - 1);

    logic [DATA_W-1:0]  sample;
    logic               sample_valid;
    logic [DATA_W-1:0]  prev_sample;
    cap_state_t         state_q;
    cap_state_t         state_d;
    trig_mode_t         mode_q;
    logic [DATA_W-1:0]  level_q;
    logic [DECIM_W-1:0] decim_q;
    logic [DECIM_W-1:0] dec_cnt;
    logic [ADR_W-1:0]   wr_adr;
    logic               trig_cond;
    logic               trig_hit;
    logic               we;
    logic               arm_ok;
    logic [DATA_W-1:0]  mem [DEPTH];

    adc_serial_rx #(
        .FRAME_BITS (FRAME_BITS),
        .LEAD_PAD   (LEAD_PAD),
        .DATA_W     (DATA_W),
        .QUIET_BITS (QUIET_BITS),
        .SCLK_DIV   (SCLK_DIV)
    ) u_rx (
        .osc_clk      (osc_clk),
        .reset        (reset),
        .adc_data     (adc_data),
        .adc_conv     (adc_conv),
        .adc_clk      (adc_clk),
        .sample       (sample),
        .sample_valid (sample_valid)
    );

    // Trigger condition for the current sample against the latched settings.
    always_comb begin
        trig_cond = 1'b0;
        case (mode_q)
            TRIG_FREE: trig_cond = 1'b1;
            TRIG_RISE: trig_cond = (prev_sample < level_q) && (sample >= level_q);
            TRIG_FALL: trig_cond = (prev_sample > level_q) && (sample <= level_q);
            TRIG_EXT:  trig_cond = trig_ext;
            default:   trig_cond = 1'b0;
        endcase
    end

    // Capture FSM next state plus write/arm strobes.
    always_comb begin
        state_d  = state_q;
        trig_hit = 1'b0;
        we       = 1'b0;
        arm_ok   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    arm_ok  = 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (sample_valid && trig_cond) begin
                    trig_hit = 1'b1;
                    we       = 1'b1;
                    state_d  = (wr_adr == LAST_ADR) ? FULL : CAPTURE;
                end
            end
            CAPTURE: begin
                if (sample_valid && (dec_cnt == decim_q)) begin
                    we = 1'b1;
                    if (wr_adr == LAST_ADR) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (arm) begin
                    arm_ok  = 1'b1;
                    state_d = ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, settings latch, write address, decimator, flag and read port.
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            state_q        <= IDLE;
            mode_q         <= TRIG_FREE;
            level_q        <= '0;
            decim_q        <= '0;
            dec_cnt        <= '0;
            wr_adr         <= '0;
            pi_signal_flag <= 1'b0;
            rd_data        <= '0;
        end else begin
            state_q        <= state_d;
            pi_signal_flag <= (state_q == FULL);
            if (arm_ok) begin
                mode_q  <= trig_mode_t'(trig_mode);
                level_q <= trig_level;
                decim_q <= decim;
                wr_adr  <= '0;
            end else if (we && (wr_adr != LAST_ADR)) begin
                wr_adr <= wr_adr + 1'b1;
            end
            if (trig_hit) begin
                dec_cnt <= '0;
            end else if ((state_q == CAPTURE) && sample_valid) begin
                dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + 1'b1;
            end
            if ((state_q == FULL) && rd_en) begin
                rd_data <= mem[rd_adr];
            end
        end
    end

    // Previous sample follows every completed frame, regardless of state.
    always_ff @(posedge osc_clk) begin
        if (sample_valid) begin
            prev_sample <= sample;
        end
    end

    // Sample buffer write port.
    always_ff @(posedge osc_clk) begin
        if (we) begin
            mem[wr_adr] <= sample;
        end
    end

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer with a serial ADC ramp model.
module tb_adc_capture_buffer;
    import oscope_pkg::*;

    logic       osc_clk = 1'b0;
    logic       reset = 1'b1;
    logic       adc_data = 1'b0;
    logic       adc_conv;
    logic       adc_clk;
    logic       arm = 1'b0;
    logic [1:0] trig_mode = 2'd0;
    logic [7:0] trig_level = 8'h00;
    logic       trig_ext = 1'b0;
    logic [7:0] decim = 8'h00;
    logic       pi_signal_flag;
    logic       rd_en = 1'b0;
    logic [3:0] rd_adr = 4'd0;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;

    // ADC model state: frame k after base_frame carries ramp_base + k*ramp_step.
    logic [7:0]  ramp_base = 8'h00;
    logic [7:0]  ramp_step = 8'h01;
    int          base_frame = 0;
    int          frame_no = 0;
    logic [15:0] cur_word = 16'h0000;
    int          bit_idx = 15;
    logic        m_prev_conv = 1'b1;
    logic        m_prev_clk = 1'b0;

    adc_capture_buffer #(
        .FRAME_BITS (16),
        .LEAD_PAD   (2),
        .DATA_W     (8),
        .QUIET_BITS (2),
        .SCLK_DIV   (2),
        .DEPTH      (16)
    ) dut (
        .osc_clk        (osc_clk),
        .reset          (reset),
        .adc_data       (adc_data),
        .adc_conv       (adc_conv),
        .adc_clk        (adc_clk),
        .arm            (arm),
        .trig_mode      (trig_mode),
        .trig_level     (trig_level),
        .trig_ext       (trig_ext),
        .decim          (decim),
        .pi_signal_flag (pi_signal_flag),
        .rd_en          (rd_en),
        .rd_adr         (rd_adr),
        .rd_data        (rd_data)
    );

    always #5 osc_clk = ~osc_clk;

    // Serial ADC: loads a new word when conv falls, presents the next bit after each SCLK rise.
    always @(negedge osc_clk) begin
        if (m_prev_conv && !adc_conv) begin
            cur_word = {2'b00, 8'(int'(ramp_base) + int'(ramp_step) * (frame_no - base_frame)), 6'b000000};
            frame_no = frame_no + 1;
            bit_idx  = 15;
            adc_data = cur_word[15];
        end else if (!adc_conv && !m_prev_clk && adc_clk) begin
            if (bit_idx > 0) bit_idx = bit_idx - 1;
            adc_data = cur_word[bit_idx];
        end
        m_prev_conv = adc_conv;
        m_prev_clk  = adc_clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge osc_clk);
    endtask

    task automatic set_ramp(input logic [7:0] base, input logic [7:0] step);
        @(posedge osc_clk);
        ramp_base  = base;
        ramp_step  = step;
        base_frame = frame_no;
    endtask

    task automatic wait_conv_fall();
        logic last;
        last = adc_conv;
        for (int n = 0; n < 400; n++) begin
            @(negedge osc_clk);
            if (last && !adc_conv) return;
            last = adc_conv;
        end
        chk("conv_fall_wait", 32'(adc_conv), 32'd0);
    endtask

    task automatic start_capture(input logic [1:0] mode, input logic [7:0] lvl,
                                 input logic [7:0] dec, input logic [7:0] base,
                                 input logic [7:0] step);
        set_ramp(base, step);
        wait_conv_fall();
        trig_mode  = mode;
        trig_level = lvl;
        decim      = dec;
        arm        = 1'b1;
        @(negedge osc_clk);
        arm        = 1'b0;
    endtask

    task automatic wait_full(input int limit);
        for (int n = 0; n < limit; n++) begin
            @(negedge osc_clk);
            if (pi_signal_flag) break;
        end
        chk("full_flag", 32'(pi_signal_flag), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        rd_adr = a;
        rd_en  = 1'b1;
        @(negedge osc_clk);
        rd_en  = 1'b0;
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int low;
        int rises;
        int svs;
        logic pc;

        // Reset values.
        repeat (5) @(posedge osc_clk);
        @(negedge osc_clk);
        chk("rst_conv", 32'(adc_conv), 32'd1);
        chk("rst_sclk", 32'(adc_clk), 32'd0);
        chk("rst_flag", 32'(pi_signal_flag), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b0;

        // Reset in the middle of a data phase.
        wait_conv_fall();
        cycles(10);
        chk("pre_mid_rst_conv", 32'(adc_conv), 32'd0);
        reset = 1'b1;
        @(negedge osc_clk);
        chk("mid_rst_conv", 32'(adc_conv), 32'd1);
        chk("mid_rst_sclk", 32'(adc_clk), 32'd0);
        reset = 1'b0;

        // Single frame of 00_10110011_000000.
        set_ramp(8'hB3, 8'h00);
        wait_conv_fall();
        low   = 1;
        rises = 0;
        svs   = 0;
        pc    = adc_clk;
        for (int n = 0; n < 200; n++) begin
            @(negedge osc_clk);
            if (adc_conv) break;
            low = low + 1;
            if (!pc && adc_clk) begin
                rises = rises + 1;
                if (rises == 16) begin
                    chk("sv_after_rise16", 32'(dut.u_rx.sample_valid), 32'd1);
                    chk("sample_b3", 32'(dut.u_rx.sample), 32'hB3);
                end
            end
            if (dut.u_rx.sample_valid) svs = svs + 1;
            pc = adc_clk;
        end
        chk("conv_low_cycles", 32'(low), 32'd64);
        chk("sclk_rises", 32'(rises), 32'd16);
        chk("sv_pulses", 32'(svs), 32'd1);

        // Free-run, every sample.
        start_capture(2'd0, 8'h00, 8'd0, 8'h00, 8'h01);
        wait_full(2000);
        chk("wr_adr_at_full", 32'(dut.wr_adr), 32'd15);
        chk("state_full", 32'(dut.state_q), 32'(FULL));
        for (int i = 0; i < 16; i++) rd_chk("ramp_mem", 4'(i), 8'(i));
        rd_chk("ramp_rd5", 4'd5, 8'd5);

        // Rising trigger at 0x80 on a ramp 70,74,78,7C,80,...
        start_capture(2'd1, 8'h80, 8'd0, 8'h70, 8'h04);
        wait_full(3000);
        rd_chk("rise_mem0", 4'd0, 8'h80);
        rd_chk("rise_mem1", 4'd1, 8'h84);
        rd_chk("rise_mem15", 4'd15, 8'hBC);

        // Falling trigger at 0x80 on a ramp 90,8C,88,84,80,...
        start_capture(2'd2, 8'h80, 8'd0, 8'h90, 8'hFC);
        wait_full(3000);
        rd_chk("fall_mem0", 4'd0, 8'h80);
        rd_chk("fall_mem1", 4'd1, 8'h7C);
        rd_chk("fall_mem15", 4'd15, 8'h44);

        // Decimation by 3.
        start_capture(2'd0, 8'h00, 8'd2, 8'h00, 8'h01);
        wait_full(5000);
        rd_chk("dec_mem0", 4'd0, 8'd0);
        rd_chk("dec_mem1", 4'd1, 8'd3);
        rd_chk("dec_mem2", 4'd2, 8'd6);
        rd_chk("dec_mem15", 4'd15, 8'd45);

        // arm during CAPTURE must not restart or re-latch settings.
        start_capture(2'd0, 8'h00, 8'd0, 8'h20, 8'h01);
        cycles(350);
        chk("state_capture", 32'(dut.state_q), 32'(CAPTURE));
        trig_mode  = 2'd1;
        trig_level = 8'hFF;
        decim      = 8'd5;
        arm        = 1'b1;
        @(negedge osc_clk);
        arm        = 1'b0;
        wait_full(2000);
        rd_chk("ign_mem0", 4'd0, 8'h20);
        rd_chk("ign_mem6", 4'd6, 8'h26);
        rd_chk("ign_mem15", 4'd15, 8'h2F);

        // Re-arm from FULL: flag drops, read port goes quiet, refill from address 0.
        start_capture(2'd0, 8'h00, 8'd0, 8'h50, 8'h01);
        cycles(2);
        chk("rearm_flag", 32'(pi_signal_flag), 32'd0);
        chk("rearm_state", 32'(dut.state_q), 32'(ARMED));
        rd_chk("rd_hold", 4'd0, 8'h2F);
        wait_full(2000);
        rd_chk("refill_mem0", 4'd0, 8'h50);
        rd_chk("refill_mem15", 4'd15, 8'h5F);

        // Reset after 7 writes.
        start_capture(2'd0, 8'h00, 8'd0, 8'h60, 8'h01);
        for (int n = 0; n < 1500; n++) begin
            @(negedge osc_clk);
            if (dut.wr_adr == 4'd7) break;
        end
        chk("wr_adr_7", 32'(dut.wr_adr), 32'd7);
        reset = 1'b1;
        @(negedge osc_clk);
        reset = 1'b0;
        chk("rst7_flag", 32'(pi_signal_flag), 32'd0);
        chk("rst7_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst7_wr_adr", 32'(dut.wr_adr), 32'd0);
        rd_chk("rst7_rd_ignored", 4'd3, 8'h00);
        cycles(200);
        chk("idle_flag", 32'(pi_signal_flag), 32'd0);
        chk("idle_state", 32'(dut.state_q), 32'(IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
